// File: rtl/sc_fir_sequencer.sv
// sc_fir_sequencer: control FSM for the stochastic-computing FIR datapath.
// Accepts one binary sample per handshake, shifts it into the tap delay line,
// runs one 2^N-cycle bitstream window, waits out the datapath pipeline and
// then holds the captured counter value on a valid/ready output.
//
//   state | meaning
//   IDLE  | ready for a sample or a flush request
//   LOAD  | one-cycle shift/seed-reload/counter-clear pulse
//   RUN   | bitstream window, SNG and counter enabled, stream_idx counting
//   DRAIN | counter absorbs in-flight bits for PIPE cycles, then capture
//   HOLD  | result presented until out_ready
module sc_fir_sequencer #(
  parameter int N      = 8,
  parameter int LENGTH = 19,
  parameter int PIPE   = 2,
  parameter int OW     = 4 * N
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  input  logic          flush,
  output logic          tap_shift,
  output logic          tap_clear,
  output logic [N-1:0]  tap_data,
  output logic          sng_load,
  output logic          sng_en,
  output logic          cnt_clear,
  output logic          cnt_en,
  output logic [N-1:0]  stream_idx,
  input  logic [OW-1:0] cnt_result,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  input  logic          out_ready,
  output logic          warm
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LENGTH);
  // Drain down-counter is loaded with PIPE-1 and captures on terminal count 0.
  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE > 0) ? PIPE - 1 : 0);
  localparam logic [N-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] sample_next;
  logic [DW-1:0] drain_cnt;

  // Saturating warm-up count of samples since reset or flush.
  always_comb begin
    sample_next = sample_cnt;
    if (sample_cnt != CNT_MAX) sample_next = sample_cnt + 1'b1;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      tap_shift  <= 1'b0;
      tap_clear  <= 1'b0;
      tap_data   <= '0;
      sng_load   <= 1'b0;
      sng_en     <= 1'b0;
      cnt_clear  <= 1'b0;
      cnt_en     <= 1'b0;
      stream_idx <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      warm       <= 1'b0;
      sample_cnt <= '0;
      drain_cnt  <= '0;
    end else begin
      tap_shift <= 1'b0;
      tap_clear <= 1'b0;
      sng_load  <= 1'b0;
      cnt_clear <= 1'b0;
      case (state)
        IDLE: begin
          // A sample offered together with flush takes priority; flush is dropped.
          if (in_valid) begin
            tap_data   <= in_data;
            tap_shift  <= 1'b1;
            sng_load   <= 1'b1;
            cnt_clear  <= 1'b1;
            in_ready   <= 1'b0;
            stream_idx <= '0;
            sample_cnt <= sample_next;
            warm       <= (sample_next == CNT_MAX);
            state      <= LOAD;
          end else if (flush) begin
            tap_clear  <= 1'b1;
            sample_cnt <= '0;
            warm       <= 1'b0;
          end
        end
        LOAD: begin
          sng_en <= 1'b1;
          cnt_en <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          if (stream_idx == IDX_LAST) begin
            stream_idx <= '0;
            sng_en     <= 1'b0;
            drain_cnt  <= DRAIN_LAST;
            if (PIPE == 0) begin
              cnt_en    <= 1'b0;
              out_data  <= cnt_result;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= DRAIN;
            end
          end else begin
            stream_idx <= stream_idx + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            cnt_en    <= 1'b0;
            out_data  <= cnt_result;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// tb_sc_fir_sequencer: directed bench for the FIR sequencer with a result
// scoreboard and a behavioural counter standing in for the datapath.
module tb_sc_fir_sequencer;

  localparam int N      = 8;
  localparam int LENGTH = 19;
  localparam int PIPE   = 2;
  localparam int OW     = 32;
  localparam int WIN    = 256;
  localparam int LAT    = WIN + PIPE + 1;   // LOAD cycle to first out_valid cycle
  localparam int PERIOD = WIN + PIPE + 3;   // back-to-back sample spacing

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          tap_shift, tap_clear, sng_load, sng_en, cnt_clear, cnt_en;
  logic [N-1:0]  tap_data, stream_idx;
  logic [OW-1:0] cnt_result = '0;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic          warm;

  int errors = 0;
  int checks = 0;
  int steps = 0;
  int prev_load = 0;
  int wcount = 0;
  logic [OW-1:0] cnt_base = '0;
  logic [OW-1:0] sbq[$];

  // Monitor totals, written only by the monitor process.
  int sng_total = 0, cnt_total = 0, shift_total = 0, clear_total = 0, idx_err = 0;
  logic [N-1:0] run_pos = '0;

  sc_fir_sequencer #(.N(N), .LENGTH(LENGTH), .PIPE(PIPE), .OW(OW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .tap_shift(tap_shift), .tap_clear(tap_clear),
    .tap_data(tap_data), .sng_load(sng_load), .sng_en(sng_en), .cnt_clear(cnt_clear),
    .cnt_en(cnt_en), .stream_idx(stream_idx), .cnt_result(cnt_result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .warm(warm)
  );

  always #5 clock = ~clock;

  // Datapath counter stand-in: cleared to a per-sample base, counts enabled cycles.
  always @(negedge clock) begin
    if (cnt_clear === 1'b1) cnt_result = cnt_base;
    else if (cnt_en === 1'b1) cnt_result = cnt_result + 1;
  end

  // Cycle monitor: enable totals, pulse totals and stream_idx contiguity.
  always @(negedge clock) begin
    if (sng_en === 1'b1) sng_total++;
    if (cnt_en === 1'b1) cnt_total++;
    if (tap_clear === 1'b1) clear_total++;
    if (tap_shift === 1'b1) begin
      shift_total++;
      run_pos = '0;
    end
    if (sng_en === 1'b1) begin
      if (stream_idx !== run_pos) idx_err++;
      run_pos = run_pos + 1'b1;
    end else if (cnt_en === 1'b1 && stream_idx !== '0) begin
      idx_err++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
    steps++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   in_ready,   1);
    chk({tag, "_tap_shift"},  tap_shift,  0);
    chk({tag, "_tap_clear"},  tap_clear,  0);
    chk({tag, "_tap_data"},   tap_data,   0);
    chk({tag, "_sng_load"},   sng_load,   0);
    chk({tag, "_sng_en"},     sng_en,     0);
    chk({tag, "_cnt_clear"},  cnt_clear,  0);
    chk({tag, "_cnt_en"},     cnt_en,     0);
    chk({tag, "_stream_idx"}, stream_idx, 0);
    chk({tag, "_out_valid"},  out_valid,  0);
    chk({tag, "_out_data"},   out_data,   0);
    chk({tag, "_warm"},       warm,       0);
  endtask

  task automatic run_sample(input logic [N-1:0] d, input logic [OW-1:0] base,
                            input bit fl, input int hold, input bit chk_tp);
    int n, lat, ts0, tc0, se0, ce0, ie0;
    logic [OW-1:0] exp;
    bit stable;
    n = 0;
    while (in_ready !== 1'b1 && n < 1000) begin step(); n++; end
    chk("idle_wait", in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    cnt_base = base;
    sbq.push_back(base + OW'(WIN + PIPE));
    tc0 = clear_total;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = ~d;
    wcount = (wcount < LENGTH) ? wcount + 1 : LENGTH;
    chk("load_tap_shift",  tap_shift,  1);
    chk("load_sng_load",   sng_load,   1);
    chk("load_cnt_clear",  cnt_clear,  1);
    chk("load_in_ready",   in_ready,   0);
    chk("load_tap_data",   tap_data,   d);
    chk("load_stream_idx", stream_idx, 0);
    chk("load_warm",       warm,       (wcount == LENGTH));
    if (chk_tp) chk("throughput", steps - prev_load, PERIOD);
    prev_load = steps;
    ts0 = shift_total; se0 = sng_total; ce0 = cnt_total; ie0 = idx_err;
    if (hold > 0) out_ready = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 600) begin step(); lat++; end
    chk("latency",      lat,               LAT);
    chk("sng_cycles",   sng_total - se0,   WIN);
    chk("cnt_cycles",   cnt_total - ce0,   WIN + PIPE);
    chk("idx_sequence", idx_err - ie0,     0);
    chk("run_no_shift", shift_total - ts0, 0);
    exp = (sbq.size() > 0) ? sbq.pop_front() : 'x;
    chk("out_data", out_data, exp);
    if (hold > 0) begin
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        step();
        if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) stable = 1'b0;
        in_valid = (k % 2 == 1);
        flush    = (k == 3);
      end
      step();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      chk("bp_stable",   stable,            1);
      chk("bp_no_shift", shift_total - ts0, 0);
    end
    chk("no_tap_clear", clear_total - tc0, 0);
    step();
    chk("ret_out_valid", out_valid, 0);
    chk("ret_in_ready",  in_ready,  1);
  endtask

  initial begin
    #500000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset");
    step();
    step();
    reset = 1'b0;

    // First sample and a back-pressured second sample.
    run_sample(8'd3, 32'h0000_1234 - 32'(WIN + PIPE), 1'b0, 0, 1'b0);
    run_sample(8'd7, 32'h0000_5000, 1'b0, 50, 1'b0);

    // Warm-up: 25 samples total, warm from the 19th and saturated after.
    for (int i = 2; i < 25; i++)
      run_sample(N'(3 + 4 * i), OW'(32'h0001_0000 * i), 1'b0, 0, (i >= 3));

    // Flush alone in IDLE clears the delay line and the warm-up count.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_tap_clear", tap_clear, 1);
    chk("flush_warm",      warm,      0);
    step();
    chk("flush_pulse_end", tap_clear, 0);
    chk("flush_in_ready",  in_ready,  1);
    wcount = 0;

    // Flush with a sample: sample accepted, no clear; then re-warm over 19 samples.
    run_sample(8'h55, 32'h00A0_0000, 1'b1, 0, 1'b0);
    for (int i = 0; i < 18; i++)
      run_sample(N'(8'h10 + 3 * i), OW'(32'h0200_0000 + 32'h100 * i), 1'b0, 0, (i > 0));

    // Reset in the middle of a window.
    in_data  = 8'h9A;
    in_valid = 1'b1;
    cnt_base = 32'h0BAD_0000;
    sbq.push_back(32'h0BAD_0000 + 32'(WIN + PIPE));
    step();
    in_valid = 1'b0;
    n = 0;
    while (stream_idx !== 8'd100 && n < 400) begin step(); n++; end
    chk("reached_idx100", stream_idx, 100);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    sbq.delete();
    step();
    step();
    reset  = 1'b0;
    wcount = 0;
    run_sample(8'hC3, 32'h0300_0000, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
